// File: rtl/opl2_host_write_if.sv
// Host bus front end for the OPL2 core: decodes address/data port writes, queues {addr,data}
// pairs and drains them as paced single-cycle register-write strobes; reads return status.
module opl2_host_write_if #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WRITE_GAP  = 84,
  parameter int unsigned ADDR_HOLD  = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] status_in,
  output logic       reg_wr_valid,
  output logic [7:0] reg_wr_address,
  output logic [7:0] reg_wr_data,
  output logic       busy,
  output logic       overflow,
  output logic       early_wr
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned GapW  = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;
  localparam int unsigned HoldW = (ADDR_HOLD > 0) ? $clog2(ADDR_HOLD + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e            state_q, state_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              wr_act, rd_act, wr_act_q, rd_act_q, wr_edge, rd_edge;
  logic [7:0]        addr_q;
  logic [HoldW-1:0]  hold_q;
  logic [15:0]       fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              push_req, full, push, pop;
  logic [15:0]       head;
  logic [7:0]        out_addr_q, out_data_q, dout_q;
  logic              overflow_q, early_q;

  assign wr_act   = !cs_n && !wr_n;
  assign rd_act   = !cs_n && !rd_n;
  assign wr_edge  = wr_act && !wr_act_q;
  // A read that coincides with an active write window is ignored.
  assign rd_edge  = rd_act && !rd_act_q && !wr_act;

  assign push_req = wr_edge && a0;
  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign push     = push_req && !full;
  assign pop      = (state_q == StIssue);
  assign count_d  = count_q + CntW'(push) - CntW'(pop);
  assign head     = fifo_q[rptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      gap_q      <= '0;
      wr_act_q   <= 1'b0;
      rd_act_q   <= 1'b0;
      addr_q     <= 8'h00;
      hold_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      out_addr_q <= 8'h00;
      out_data_q <= 8'h00;
      dout_q     <= 8'h00;
      overflow_q <= 1'b0;
      early_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      wr_act_q <= wr_act;
      rd_act_q <= rd_act;
      count_q  <= count_d;
      if (wr_edge && !a0) begin
        addr_q <= din;
        hold_q <= HoldW'(ADDR_HOLD);
      end else if (hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end
      if (push)                       wptr_q     <= wptr_q + 1'b1;
      if (pop)                        rptr_q     <= rptr_q + 1'b1;
      if (pop)                        out_addr_q <= head[15:8];
      if (pop)                        out_data_q <= head[7:0];
      if (push_req && full)           overflow_q <= 1'b1;
      if (push_req && hold_q != '0)   early_q    <= 1'b1;
      if (rd_edge)                    dout_q     <= a0 ? 8'hFF : status_in;
    end
  end

  // Storage needs no reset: entries are only observed after being written.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= {addr_q, din};
  end

  // Gap counter counts down the WRITE_GAP-1 idle cycles between strobes; leaving GAP
  // as it expires keeps back-to-back strobes exactly WRITE_GAP cycles apart.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StIssue;
      end
      StIssue: begin
        if (WRITE_GAP == 1) begin
          state_d = (count_d != '0) ? StIssue : StIdle;
        end else begin
          gap_d   = GapW'(WRITE_GAP - 1);
          state_d = StGap;
        end
      end
      StGap: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GapW'(1)) state_d = (count_q != '0) ? StIssue : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign reg_wr_valid   = (state_q == StIssue);
  assign reg_wr_address = reg_wr_valid ? head[15:8] : out_addr_q;
  assign reg_wr_data    = reg_wr_valid ? head[7:0]  : out_data_q;
  assign busy           = (state_q != StIdle) || (count_q != '0);
  assign overflow       = overflow_q;
  assign early_wr       = early_q;
  assign dout           = dout_q;

endmodule

// File: tb/tb_opl2_host_write_if.sv
// Randomised and directed bench for opl2_host_write_if against a timestamp-based model.
module tb_opl2_host_write_if;

  localparam int Depth = 4;
  localparam int Gap   = 84;
  localparam int Hold  = 12;
  localparam int Inf   = 32'h3fffffff;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0;
  logic [7:0] din = 8'h00, status_in = 8'h00;
  logic [7:0] dout, reg_wr_address, reg_wr_data;
  logic       reg_wr_valid, busy, overflow, early_wr;

  opl2_host_write_if #(
    .FIFO_DEPTH(Depth),
    .WRITE_GAP (Gap),
    .ADDR_HOLD (Hold)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cs_n          (cs_n),
    .wr_n          (wr_n),
    .rd_n          (rd_n),
    .a0            (a0),
    .din           (din),
    .dout          (dout),
    .status_in     (status_in),
    .reg_wr_valid  (reg_wr_valid),
    .reg_wr_address(reg_wr_address),
    .reg_wr_data   (reg_wr_data),
    .busy          (busy),
    .overflow      (overflow),
    .early_wr      (early_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Model: each accepted write carries its push cycle and its scheduled strobe cycle.
  typedef struct {
    int         push;
    int         issue;
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t       ents[$];
  logic [7:0] m_addr = 8'h00;
  int         m_addr_cyc = 0;
  bit         m_addr_seen = 1'b0;
  int         m_ovf_since = Inf;
  int         m_early_since = Inf;
  logic [7:0] m_dout = 8'h00, m_dout_pend = 8'h00;
  int         m_pend_cyc = -1;
  logic [7:0] m_last_a = 8'h00, m_last_d = 8'h00;

  // Observed strobe history
  int         s_cnt = 0;
  int         s_cyc[$];
  logic [7:0] s_last_a = 8'h00, s_last_d = 8'h00;

  function automatic void model_reset();
    ents.delete();
    m_addr = 8'h00; m_addr_seen = 1'b0; m_addr_cyc = 0;
    m_ovf_since = Inf; m_early_since = Inf;
    m_dout = 8'h00; m_pend_cyc = -1;
    m_last_a = 8'h00; m_last_d = 8'h00;
  endfunction

  function automatic void model_event(input logic a0v, input logic w, input logic r,
                                      input logic [7:0] d, input logic [7:0] st, input int e);
    int occ;
    int iss;
    if (w) begin
      if (!a0v) begin
        m_addr = d; m_addr_cyc = e; m_addr_seen = 1'b1;
      end else begin
        if (m_addr_seen && (e - m_addr_cyc) <= Hold && m_early_since > e + 1)
          m_early_since = e + 1;
        occ = 0;
        foreach (ents[i]) if (ents[i].push < e && ents[i].issue >= e) occ++;
        if (occ >= Depth) begin
          if (m_ovf_since > e + 1) m_ovf_since = e + 1;
        end else begin
          iss = e + 2;
          if (ents.size() > 0 && ents[ents.size()-1].issue + Gap > iss)
            iss = ents[ents.size()-1].issue + Gap;
          ents.push_back('{e, iss, m_addr, d});
        end
      end
    end else if (r) begin
      m_dout_pend = a0v ? 8'hFF : st;
      m_pend_cyc  = e + 1;
    end
  endfunction

  always @(negedge clk) begin
    logic       exp_v, exp_busy;
    logic [7:0] ea, ed;
    if (m_pend_cyc >= 0 && cyc >= m_pend_cyc) begin
      m_dout = m_dout_pend; m_pend_cyc = -1;
    end
    exp_v = 1'b0; exp_busy = 1'b0; ea = m_last_a; ed = m_last_d;
    foreach (ents[i]) begin
      if (ents[i].issue == cyc) begin exp_v = 1'b1; ea = ents[i].a; ed = ents[i].d; end
      if (ents[i].push < cyc && ents[i].issue >= cyc) exp_busy = 1'b1;
      if (ents[i].issue < cyc && cyc - ents[i].issue < Gap) exp_busy = 1'b1;
    end
    check("valid", 32'(reg_wr_valid), 32'(exp_v));
    check("addr", 32'(reg_wr_address), 32'(ea));
    check("data", 32'(reg_wr_data), 32'(ed));
    check("busy", 32'(busy), 32'(exp_busy));
    check("overflow", 32'(overflow), 32'(cyc >= m_ovf_since));
    check("early_wr", 32'(early_wr), 32'(cyc >= m_early_since));
    check("dout", 32'(dout), 32'(m_dout));
    if (exp_v) begin m_last_a = ea; m_last_d = ed; end
    if (reg_wr_valid) begin
      s_cnt++; s_cyc.push_back(cyc); s_last_a = reg_wr_address; s_last_d = reg_wr_data;
    end
  end

  // One host access window of len cycles followed by one inactive cycle; e = edge cycle.
  task automatic op(input logic a0v, input logic w, input logic r, input logic [7:0] d,
                    input logic [7:0] st, input int len, output int e);
    @(posedge clk); #1;
    cs_n = 1'b0; wr_n = !w; rd_n = !r; a0 = a0v; din = d; status_in = st;
    e = cyc;
    model_event(a0v, w, r, d, st, cyc);
    repeat (len) @(posedge clk);
    #1;
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      cs_n = 1'b1; wr_n = 1'($urandom); rd_n = 1'($urandom); din = 8'($urandom);
    end
    wr_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    model_reset();
    #2;
    check("rst_valid", 32'(reg_wr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(reg_wr_address), 32'd0);
    check("rst_data", 32'(reg_wr_data), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_flags", 32'({overflow, early_wr}), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int e, e0, base, k;
    logic [7:0] d;
    do_reset();
    idle(3);

    // Address then data write: one strobe two cycles after the data edge
    base = s_cnt;
    op(1'b0, 1'b1, 1'b0, 8'h04, 8'h00, 1, e);
    op(1'b1, 1'b1, 1'b0, 8'h80, 8'h00, 1, e);
    idle(100);
    check("t1_count", 32'(s_cnt - base), 32'd1);
    check("t1_lat", 32'(s_cyc[s_cyc.size()-1] - e), 32'd2);
    check("t1_addr", 32'(s_last_a), 32'h04);
    check("t1_data", 32'(s_last_d), 32'h80);

    do_reset();
    idle(3);
    // Held write window counts once
    base = s_cnt;
    op(1'b1, 1'b1, 1'b0, 8'h5A, 8'h00, 10, e);
    idle(100);
    check("t4_count", 32'(s_cnt - base), 32'd1);

    // Three back-to-back data writes: strobes WRITE_GAP apart
    op(1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1, e);
    idle(20);
    base = s_cnt;
    k = s_cyc.size();
    op(1'b1, 1'b1, 1'b0, 8'h11, 8'h00, 1, e);
    op(1'b1, 1'b1, 1'b0, 8'h22, 8'h00, 1, e);
    op(1'b1, 1'b1, 1'b0, 8'h33, 8'h00, 1, e);
    idle(300);
    check("t2_count", 32'(s_cnt - base), 32'd3);
    if (s_cyc.size() >= k + 3) begin
      check("t2_gap1", 32'(s_cyc[k+1] - s_cyc[k]), 32'(Gap));
      check("t2_gap2", 32'(s_cyc[k+2] - s_cyc[k+1]), 32'(Gap));
    end
    check("t2_last", 32'(s_last_d), 32'h33);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_early", 32'(early_wr), 32'd0);

    // Data write three cycles after an address write is flagged but still emitted
    base = s_cnt;
    op(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1, e0);
    idle(1);
    op(1'b1, 1'b1, 1'b0, 8'h77, 8'h00, 1, e);
    check("t5_dist", 32'(e - e0), 32'd3);
    idle(100);
    check("t5_early", 32'(early_wr), 32'd1);
    check("t5_count", 32'(s_cnt - base), 32'd1);
    check("t5_addr", 32'(s_last_a), 32'h20);

    // DEPTH+2 writes with no gap: DEPTH+1 emitted, one dropped
    base = s_cnt;
    for (int i = 0; i < Depth + 2; i++) op(1'b1, 1'b1, 1'b0, 8'(8'hA0 + i), 8'h00, 1, e);
    idle(Gap * (Depth + 1) + 20);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_count", 32'(s_cnt - base), 32'(Depth + 1));
    check("t3_last", 32'(s_last_d), 32'(8'hA0 + Depth));

    // Status reads
    op(1'b0, 1'b0, 1'b1, 8'h00, 8'hE0, 1, e);
    check("t6_status", 32'(dout), 32'hE0);
    idle(2);
    check("t6_hold", 32'(dout), 32'hE0);
    op(1'b1, 1'b0, 1'b1, 8'h00, 8'hE0, 1, e);
    check("t6_data_port", 32'(dout), 32'hFF);

    // Reset during GAP with two entries queued
    for (int i = 0; i < 3; i++) op(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i), 8'h00, 1, e);
    idle(10);
    check("t7_busy_pre", 32'(busy), 32'd1);
    do_reset();
    base = s_cnt;
    idle(300);
    check("t7_no_strobe", 32'(s_cnt - base), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 90; i++) begin
      k = $urandom_range(0, 5);
      d = 8'($urandom);
      case (k)
        0:       op(1'b0, 1'b1, 1'b0, d, 8'h00, $urandom_range(1, 3), e);
        1, 2:    op(1'b1, 1'b1, 1'b0, d, 8'h00, $urandom_range(1, 3), e);
        3:       op(1'($urandom), 1'b0, 1'b1, d, {3'($urandom), 5'b0}, $urandom_range(1, 3), e);
        default: op(1'($urandom), 1'b1, 1'b1, d, {3'($urandom), 5'b0}, $urandom_range(1, 2), e);
      endcase
      idle(($urandom_range(0, 7) == 0) ? $urandom_range(80, 200) : $urandom_range(0, 30));
      if (i == 45) do_reset();
    end
    idle(Gap * (Depth + 1) + 20);
    check("end_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
